// File: rtl/mul_wb_stage.sv
// mul_wb_stage
// ------------
// Writeback stage for the pipelined 32x32 multiplier in the MUL slot.
// Each accepted issue is tracked through the multiplier's fixed latency in a
// delay line of {valid, op, rd, corr}. The tail entry lines up with the
// unsigned 64-bit product on prod_in. The signed high-half correction is
// subtracted, the result half is selected, and the result is registered
// onto the register-file write port.
//
// Handshake: both sides are valid-only. An issue is taken in any cycle with
// issue_valid=1 and flush=0; there is no ready/stall path. The write port
// pulses wb_valid for exactly one cycle per retired op, and the register
// file always accepts it.
//
// Ports
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   issue_valid       op presented to the multiplier this cycle
//   issue_op          00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   issue_rd          destination register tag
//   issue_a, issue_b  operands, identical to the multiplier inputs
//   flush             kill every in-flight op
//   prod_in           unsigned 64-bit product from the multiplier
//   wb_valid/rd/data  registered register-file write port
//   busy              ops in flight or a write pending on the port
//   inflight_cnt      number of valid delay-line entries
module mul_wb_stage #(
  parameter int MUL_LAT = 10,
  parameter int CNT_W   = $clog2(MUL_LAT + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [1:0]       issue_op,
  input  logic [4:0]       issue_rd,
  input  logic [31:0]      issue_a,
  input  logic [31:0]      issue_b,
  input  logic             flush,
  input  logic [63:0]      prod_in,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic             busy,
  output logic [CNT_W-1:0] inflight_cnt
);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  // Delay line; index 0 is the newest entry, MUL_LAT-1 is aligned with prod_in.
  logic [MUL_LAT-1:0] r_vld;
  logic [1:0]         r_op   [MUL_LAT];
  logic [4:0]         r_rd   [MUL_LAT];
  logic [31:0]        r_corr [MUL_LAT];

  logic             r_wb_valid;
  logic [4:0]       r_wb_rd;
  logic [31:0]      r_wb_data;
  logic [CNT_W-1:0] r_cnt;

  logic        w_issue;
  logic        w_tail_vld;
  logic        w_retire;
  logic [31:0] w_a_term;
  logic [31:0] w_b_term;
  logic [31:0] w_corr;
  logic [31:0] w_result;

  assign w_issue    = issue_valid & ~flush;
  assign w_tail_vld = r_vld[MUL_LAT-1];
  // A retire in the flush cycle is suppressed as well.
  assign w_retire   = w_tail_vld & ~flush;

  // The multiplier treats both operands as unsigned. For a negative signed
  // operand x, x_signed = x_unsigned - 2^32, so the high half of the signed
  // product is the unsigned high half minus the other operand for each
  // negative signed operand. The adder carry-out is intentionally dropped.
  assign w_a_term = issue_a[31] ? issue_b : 32'd0;
  assign w_b_term = issue_b[31] ? issue_a : 32'd0;

  always_comb begin
    w_corr = 32'd0;
    case (issue_op)
      OP_MULH:   w_corr = w_a_term + w_b_term;
      OP_MULHSU: w_corr = w_a_term;
      default:   w_corr = 32'd0;
    endcase
  end

  always_comb begin
    w_result = prod_in[63:32] - r_corr[MUL_LAT-1];
    if (r_op[MUL_LAT-1] == OP_MUL) begin
      w_result = prod_in[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld      <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= 32'd0;
      r_cnt      <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        r_op[i]   <= 2'd0;
        r_rd[i]   <= 5'd0;
        r_corr[i] <= 32'd0;
      end
    end else begin
      // Shift the delay line; a flush clears every valid bit at this edge.
      for (int i = MUL_LAT - 1; i > 0; i--) begin
        r_vld[i]  <= r_vld[i-1] & ~flush;
        r_op[i]   <= r_op[i-1];
        r_rd[i]   <= r_rd[i-1];
        r_corr[i] <= r_corr[i-1];
      end
      r_vld[0]  <= w_issue;
      r_op[0]   <= issue_op;
      r_rd[0]   <= issue_rd;
      r_corr[0] <= w_corr;

      // wb_rd/wb_data hold their last values when nothing retires.
      r_wb_valid <= w_retire;
      if (w_retire) begin
        r_wb_rd   <= r_rd[MUL_LAT-1];
        r_wb_data <= w_result;
      end

      // Issue and retire in the same cycle cancel; the count cannot exceed
      // MUL_LAT because a full line always retires from its tail.
      if (flush) begin
        r_cnt <= '0;
      end else if (w_issue && !w_tail_vld) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (!w_issue && w_tail_vld) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign wb_valid     = r_wb_valid;
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign inflight_cnt = r_cnt;
  assign busy         = (r_cnt != '0) | r_wb_valid;

endmodule

// File: tb/tb_mul_wb_stage.sv
// tb_mul_wb_stage
// ---------------
// Testbench for mul_wb_stage. It models the multiplier as a MUL_LAT-deep
// product pipeline feeding prod_in. A scoreboard queue holds, for each
// accepted issue, the cycle its write must appear, the rd and data, and the
// edge at which a flush or reset kills it. A negedge monitor checks every
// cycle's write port, inflight_cnt and busy against that queue.
module tb_mul_wb_stage;

  localparam int L  = 10;
  localparam int CW = $clog2(L + 2);
  // Scoreboard entry: {kill_cycle[100:69], wb_cycle[68:37], rd[36:32], data[31:0]}
  localparam int W  = 101;
  localparam logic [31:0] NEVER = 32'h7FFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          issue_valid;
  logic [1:0]    issue_op;
  logic [4:0]    issue_rd;
  logic [31:0]   issue_a;
  logic [31:0]   issue_b;
  logic          flush;
  logic [63:0]   prod_in;
  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;
  logic          busy;
  logic [CW-1:0] inflight_cnt;

  mul_wb_stage #(.MUL_LAT(L), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_op     (issue_op),
    .issue_rd     (issue_rd),
    .issue_a      (issue_a),
    .issue_b      (issue_b),
    .flush        (flush),
    .prod_in      (prod_in),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .busy         (busy),
    .inflight_cnt (inflight_cnt)
  );

  // ---------------- clock / reset / multiplier model ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= {32'd0, issue_a} * {32'd0, issue_b};
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign prod_in = pipe[L-1];

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           total = 0;
  int           bad = 0;
  bit           mon_en = 1'b0;
  int           rst_edge = -1;
  int           max_cnt = 0;
  logic [4:0]   last_rd = 5'd0;
  logic [31:0]  last_data = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference result from full sign-extended 64-bit products.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      2'd0:    begin p = {32'd0, a} * {32'd0, b};             return p[31:0];  end
      2'd1:    begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      2'd2:    begin p = {{32{a[31]}}, a} * {32'd0, b};       return p[63:32]; end
      default: begin p = {32'd0, a} * {32'd0, b};             return p[63:32]; end
    endcase
  endfunction

  // Mark every op whose write would land at or after edge k as killed.
  task automatic kill_from(input int k);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (int'(exp_q[i][68:37]) >= k && int'(exp_q[i][100:69]) > k)
        exp_q[i][100:69] = k;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] expv);
    step();
    issue_valid = 1'b1;
    issue_op    = op;
    issue_a     = a;
    issue_b     = b;
    issue_rd    = rd;
    exp_q.push_back({NEVER, 32'(cyc + L + 1), rd, expv});
  endtask

  task automatic flush_op(input bit with_issue);
    step();
    flush       = 1'b1;
    issue_valid = with_issue;
    issue_op    = 2'($urandom_range(0, 3));
    issue_a     = $urandom;
    issue_b     = $urandom;
    issue_rd    = 5'($urandom_range(0, 31));
    kill_from(cyc + 1);
  endtask

  task automatic rst_pulse();
    step();
    rst_n = 1'b0;
    kill_from(cyc + 1);
    rst_edge = cyc + 1;
    step();
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_rd", 64'(wb_rd), 64'd0);
    check("rst_wb_data", 64'(wb_data), 64'd0);
    check("rst_inflight", 64'(inflight_cnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    int          mc;
    bit          ew;
    logic [4:0]  er;
    logic [31:0] ed;
    if (mon_en) begin
      if (cyc == rst_edge) begin
        last_rd   = 5'd0;
        last_data = 32'd0;
      end
      mc = 0;
      ew = 1'b0;
      er = 5'd0;
      ed = 32'd0;
      foreach (exp_q[i]) begin
        if (cyc >= int'(exp_q[i][68:37]) - L && cyc < int'(exp_q[i][68:37]) &&
            cyc < int'(exp_q[i][100:69]))
          mc++;
        if (cyc == int'(exp_q[i][68:37]) && cyc < int'(exp_q[i][100:69])) begin
          ew = 1'b1;
          er = exp_q[i][36:32];
          ed = exp_q[i][31:0];
        end
      end
      check("wb_valid", 64'(wb_valid), 64'(ew));
      if (ew) begin
        check("wb_rd", 64'(wb_rd), 64'(er));
        check("wb_data", 64'(wb_data), 64'(ed));
        last_rd   = er;
        last_data = ed;
      end else begin
        check("wb_rd_hold", 64'(wb_rd), 64'(last_rd));
        check("wb_data_hold", 64'(wb_data), 64'(last_data));
      end
      check("inflight_cnt", 64'(inflight_cnt), 64'(mc));
      check("busy", 64'(busy), 64'((mc != 0) || ew));
      if (int'(inflight_cnt) > max_cnt) max_cnt = int'(inflight_cnt);
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (int'(exp_q[i][68:37]) <= cyc) exp_q.delete(i);
      end
    end
  end

  // ---------------- test ----------------
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] expv;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{2'd0, 32'd3,         32'd5,         5'd7,  32'h0000_000F};
    vecs[1]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000};
    vecs[2]  = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE};
    vecs[3]  = '{2'd2, 32'hFFFF_FFFF, 32'd2,         5'd3,  32'hFFFF_FFFF};
    vecs[4]  = '{2'd1, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000};
    vecs[5]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0001};
    vecs[6]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  32'h8000_0000};
    vecs[7]  = '{2'd1, 32'h7FFF_FFFF, 32'h8000_0000, 5'd8,  32'hC000_0000};
    vecs[8]  = '{2'd3, 32'h8000_0000, 32'd2,         5'd9,  32'h0000_0001};
    vecs[9]  = '{2'd1, 32'hFFFF_FFFF, 32'd5,         5'd10, 32'hFFFF_FFFF};
    vecs[10] = '{2'd2, 32'd5,         32'hFFFF_FFFF, 5'd11, 32'h0000_0004};
    vecs[11] = '{2'd0, 32'h1234_5678, 32'h10,        5'd31, 32'h2345_6780};

    rst_n       = 1'b0;
    issue_valid = 1'b0;
    issue_op    = 2'd0;
    issue_rd    = 5'd0;
    issue_a     = 32'd0;
    issue_b     = 32'd0;
    flush       = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_wb_valid", 64'(wb_valid), 64'd0);
    check("reset_wb_rd", 64'(wb_rd), 64'd0);
    check("reset_wb_data", 64'(wb_data), 64'd0);
    check("reset_inflight", 64'(inflight_cnt), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    step();
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Isolated single MUL: one-cycle write pulse at the expected latency
    issue(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].rd, vecs[0].expv);
    idle(L + 3);

    // Table vectors back-to-back
    for (int i = 0; i < 12; i++)
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].expv);
    idle(L + 3);

    // Stream 2*L MULs of i*(i+1); inflight_cnt saturates at L then drains
    max_cnt = 0;
    for (int i = 0; i < 2 * L; i++)
      issue(2'd0, 32'(i), 32'(i + 1), 5'(i % 32), 32'(i * (i + 1)));
    idle(L + 4);
    check("stream_max_inflight", 64'(max_cnt), 64'(L));
    check("stream_busy_drop", 64'(busy), 64'd0);

    // Flush with four ops in flight and a simultaneous issue
    for (int i = 0; i < 4; i++)
      issue(2'($urandom_range(0, 3)), $urandom, $urandom, 5'(20 + i), 32'd0);
    flush_op(1'b1);
    step();
    check("flush_inflight_zero", 64'(inflight_cnt), 64'd0);
    idle(L + 3);
    issue(2'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd12,
          model(2'd3, 32'hDEAD_BEEF, 32'h1234_5678));
    idle(L + 3);

    // Flush in the same cycle the tail is valid: retire suppressed
    issue(2'd0, 32'd7, 32'd9, 5'd13, 32'd63);
    idle(L - 1);
    flush_op(1'b0);
    idle(L + 3);

    // Flush one cycle after a write: that write stands, the next op is killed
    issue(2'd0, 32'd11, 32'd13, 5'd14, 32'd143);
    issue(2'd0, 32'd17, 32'd19, 5'd15, 32'd323);
    idle(L - 1);
    flush_op(1'b0);
    idle(L + 3);

    // Reset pulse with three ops in flight
    for (int i = 0; i < 3; i++)
      issue(2'd1, $urandom, $urandom, 5'(24 + i), 32'd0);
    idle(2);
    rst_pulse();
    idle(L + 3);
    issue(2'd2, 32'hF000_0001, 32'h0000_0003, 5'd16,
          model(2'd2, 32'hF000_0001, 32'h0000_0003));
    idle(L + 3);

    // Random traffic with random gaps
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) idle(1);
      issue(op, a, b, 5'($urandom_range(0, 31)), model(op, a, b));
    end
    idle(L + 4);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("final_busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
